ysyx_ifu: RTL and testbench

YSYX_IFU -- requirements
Module: ysyx_ifu

---
 rtl/ysyx_ifu_pkg.sv | 15 +
 rtl/ysyx_ifu_timer.sv | 29 ++
 rtl/ysyx_ifu.sv | 140 ++++++++++++++
 tb/tb_ysyx_ifu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and constants.
package ysyx_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ      = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_PC  = 2'd3
  } ifu_state_t;

  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IFU_FAULT_INST = 32'h0000_0000;
  localparam logic [7:0]  IFU_MAX_WAIT   = 8'd255;

endpackage

// File: rtl/ysyx_ifu_timer.sv
// Response-wait timer: counts cycles while enabled, flags the cycle whose
// increment would make the count reach MAX_WAIT.
module ysyx_ifu_timer #(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [7:0] r_cnt;

  // Wait counter: clear on request acceptance, advance on each idle wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Expiry is qualified by enable so a response in the same cycle wins.
  assign o_expire = i_en && (r_cnt == (MAX_WAIT - 8'd1));

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: issues one fetch, holds the result for the decoder,
// then waits for writeback to supply the next PC.
//
//   state       | meaning
//   ST_REQ      | request valid on the bus (or misaligned fault taken directly)
//   ST_WAIT_RSP | request accepted, waiting for response or timeout
//   ST_HOLD     | instruction offered to decoder
//   ST_WAIT_PC  | waiting for writeback next-PC
module ysyx_ifu
  import ysyx_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [7:0]  MAX_WAIT = IFU_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic        imem_rsp_err,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_upd,
  output logic [31:0] fetch_cnt
);

  ifu_state_t  r_state;
  ifu_state_t  w_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_fault;
  logic [31:0] r_fetch_cnt;

  logic w_misaligned;
  logic w_req_fire;
  logic w_rsp_take;
  logic w_wait_idle;
  logic w_timeout;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_req_fire   = (r_state == ST_REQ) && !w_misaligned && imem_req_ready;
  assign w_rsp_take   = (r_state == ST_WAIT_RSP) && imem_rsp_valid;
  assign w_wait_idle  = (r_state == ST_WAIT_RSP) && !imem_rsp_valid;

  ysyx_ifu_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_req_fire),
    .i_en     (w_wait_idle),
    .o_expire (w_timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_misaligned)    w_next = ST_HOLD;
        else if (w_req_fire) w_next = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (w_rsp_take || w_timeout) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (inst_ready) w_next = ST_WAIT_PC;
      end
      ST_WAIT_PC: begin
        if (pc_upd_valid) w_next = ST_REQ;
      end
      default: w_next = ST_REQ;
    endcase
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      ST_REQ:  imem_req_valid = !w_misaligned;
      ST_HOLD: inst_valid     = 1'b1;
      default: ;
    endcase
  end

  // PC advances only when writeback supplies the next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if ((r_state == ST_WAIT_PC) && pc_upd_valid) begin
      r_pc <= pc_upd;
    end
  end

  // Instruction/fault latch, written only on the transition into HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst  <= IFU_FAULT_INST;
      r_fault <= 1'b0;
    end else if ((r_state == ST_REQ) && w_misaligned) begin
      r_inst  <= IFU_FAULT_INST;
      r_fault <= 1'b1;
    end else if (w_rsp_take) begin
      r_inst  <= imem_rsp_data;
      r_fault <= imem_rsp_err;
    end else if (w_timeout) begin
      r_inst  <= IFU_FAULT_INST;
      r_fault <= 1'b1;
    end
  end

  // Count instructions handed to the decoder; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
    end else if ((r_state == ST_HOLD) && inst_ready) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign inst_fault = r_fault;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: expected fetch results are queued as
// responses are driven and compared when the IFU offers an instruction.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;
  logic [31:0] fetch_cnt;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  ysyx_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_err   (imem_rsp_err),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .inst_fault     (inst_fault),
    .pc_upd_valid   (pc_upd_valid),
    .pc_upd         (pc_upd),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] i, input logic f);
    exp_t e;
    e.inst  = i;
    e.pc    = m_pc;
    e.fault = f;
    sb_q.push_back(e);
  endtask

  task automatic wait_req(input string tag);
    int i;
    i = 0;
    while (!imem_req_valid && i < 20) begin
      tick();
      i++;
    end
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, imem_addr, m_pc);
  endtask

  // Issue one fetch; optionally drive a junk response in the acceptance cycle.
  task automatic issue(input logic [31:0] data, input logic err, input int delay, input logic early);
    wait_req("issue");
    imem_req_ready = 1'b1;
    if (early) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0BAD;
      imem_rsp_err   = 1'b1;
    end
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("req_dropped", {31'd0, imem_req_valid}, 32'd0);
    repeat (delay) tick();
    chk("no_early_hold", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    push_exp(data, err);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'd0;
  endtask

  task automatic expect_hold(input string tag);
    int   i;
    exp_t e;
    i = 0;
    while (!inst_valid && i < 300) begin
      tick();
      i++;
    end
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard got=empty exp=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_inst"}, inst, e.inst);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_fault"}, {31'd0, inst_fault}, {31'd0, e.fault});
    end
  endtask

  task automatic accept(input int stall);
    logic [31:0] i0;
    logic [31:0] p0;
    i0 = inst;
    p0 = pc;
    repeat (stall) begin
      tick();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, i0);
      chk("stall_pc", pc, p0);
      chk("stall_cnt", fetch_cnt, m_cnt);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    m_cnt++;
    chk("acc_valid", {31'd0, inst_valid}, 32'd0);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic update(input logic [31:0] npc);
    pc_upd_valid = 1'b1;
    pc_upd       = npc;
    tick();
    pc_upd_valid = 1'b0;
    m_pc = npc;
    chk("pc_upd", pc, m_pc);
  endtask

  initial begin
    logic [31:0] base;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    pc_upd_valid   = 1'b0;
    pc_upd         = 32'd0;
    m_pc           = RST_PC;
    m_cnt          = 32'd0;

    // Reset state
    repeat (2) tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", {31'd0, inst_fault}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);

    // Basic fetch, decoder stall, acceptance
    issue(32'h0010_0093, 1'b0, 0, 1'b0);
    expect_hold("basic");
    accept(5);
    update(32'h8000_0004);

    // Same-cycle response ignored, delayed real response used
    issue(32'h0020_0113, 1'b0, 3, 1'b1);
    expect_hold("early_rsp");
    accept(0);
    update(32'h8000_0006);

    // Misaligned PC skips the bus
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    push_exp(32'd0, 1'b1);
    expect_hold("misalign");
    accept(0);
    update(32'h8000_0008);

    // Bus error; pc update during HOLD is ignored
    issue(32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    expect_hold("bus_err");
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h8000_1234;
    repeat (2) tick();
    pc_upd_valid = 1'b0;
    chk("hold_pc_ignore", pc, m_pc);
    chk("hold_still_valid", {31'd0, inst_valid}, 32'd1);
    accept(0);
    update(32'h8000_0010);

    // Timeout after MAX_WAIT idle cycles; stray response ignored
    wait_req("to");
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (254) tick();
    chk("to_not_yet", {31'd0, inst_valid}, 32'd0);
    tick();
    push_exp(32'd0, 1'b1);
    expect_hold("timeout");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    chk("stray_inst", inst, 32'd0);
    chk("stray_fault", {31'd0, inst_fault}, 32'd1);
    accept(0);
    update(32'h8000_0100);

    // Throughput: everything ready -> one instruction per 4 cycles
    wait_req("tp");
    base           = m_cnt;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    inst_ready     = 1'b1;
    pc_upd_valid   = 1'b1;
    pc_upd         = 32'h8000_0100;
    repeat (20) tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    pc_upd_valid   = 1'b0;
    m_cnt = base + 32'd5;
    chk("tp_cnt", fetch_cnt, m_cnt);
    chk("tp_req", {31'd0, imem_req_valid}, 32'd1);
    chk("tp_inst", inst, 32'h0000_0013);

    // Reset while waiting for a response; late response must be dropped
    wait_req("mid");
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", fetch_cnt, 32'd0);
    rst   = 1'b0;
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    chk("mid_pc", pc, RST_PC);
    chk("mid_req", {31'd0, imem_req_valid}, 32'd1);
    tick();
    chk("mid_ignored", {31'd0, inst_valid}, 32'd0);
    chk("mid_inst", inst, 32'd0);
    issue(32'h0000_0513, 1'b0, 1, 1'b0);
    expect_hold("post_mid");
    accept(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
